// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - shared types and segment lookup for the seven-segment display mux
package seven_segment_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic {BLANK, SHOW} scan_state_t;

   // Active-low {g,f,e,d,c,b,a}; non-BCD codes render dark
   function automatic logic [6:0] seg_pattern(input logic [3:0] bcd);
      logic [6:0] seg;
      case (bcd)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seven_segment_decode.sv
// rtl/seven_segment_decode.sv - combinational BCD to active-low seven-segment decoder
module seven_segment_decode
   import seven_segment_pkg::*;
(
   input  logic [3:0] bcd_in,
   output logic [6:0] seg_out
);

   always_comb begin
      seg_out = seg_pattern(bcd_in);
   end

endmodule

// File: rtl/seven_segment_mux.sv
// rtl/seven_segment_mux.sv - double-buffered multiplexed seven-segment driver; option LEADING_ZERO_BLANK_EN
module seven_segment_mux
   import seven_segment_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 1000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [4*NUM_DIGITS-1:0]   digits_in,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [6:0]                led_out,
   output logic                      dp_out,
   output logic [NUM_DIGITS-1:0]     digit_sel,
   output logic                      frame_done
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(NUM_DIGITS - 1);

   scan_state_t               state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0]   front_dig_q, front_dig_d, back_dig_q, back_dig_d;
   logic [NUM_DIGITS-1:0]     front_dp_q, front_dp_d, back_dp_q, back_dp_d;
   logic                      pending_q, pending_d;
   logic                      in_ready_q, in_ready_d;
   logic [6:0]                led_q, led_d;
   logic                      dp_q, dp_d;
   logic [NUM_DIGITS-1:0]     sel_q, sel_d;
   logic                      frame_done_q, frame_done_d;

   logic                      accept;
   logic                      frame_last;
   logic [3:0]                digit_code;
   logic [6:0]                digit_seg;
   logic [NUM_DIGITS-1:0]     lz_blank;

   assign accept     = in_valid && in_ready_q;
   assign frame_last = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

   always_comb begin
      cnt_d   = cnt_q + 1'b1;
      idx_d   = idx_q;
      state_d = state_q;
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      case (state_q)
         BLANK:   if (cnt_q == CNT_BLANK_LAST) state_d = SHOW;
         SHOW:    if (cnt_q == CNT_LAST) state_d = BLANK;
         default: state_d = BLANK;
      endcase
   end

   // Accept and swap cannot coincide: accept needs pending clear, swap needs it set
   always_comb begin
      back_dig_d  = back_dig_q;
      back_dp_d   = back_dp_q;
      front_dig_d = front_dig_q;
      front_dp_d  = front_dp_q;
      pending_d   = pending_q;
      if (accept) begin
         back_dig_d = digits_in;
         back_dp_d  = dp_in;
         pending_d  = 1'b1;
      end
      if (frame_last && pending_q) begin
         front_dig_d = back_dig_q;
         front_dp_d  = back_dp_q;
         pending_d   = 1'b0;
      end
      in_ready_d = !pending_d;
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic lz_run;
   always_comb begin
      lz_blank = '0;
      lz_run   = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         lz_run      = lz_run && (front_dig_d[4*i +: 4] == 4'd0);
         lz_blank[i] = lz_run;
      end
   end
`else
   assign lz_blank = '0;
`endif

   assign digit_code = front_dig_d[4*idx_d +: 4];

   seven_segment_decode u_decode (
      .bcd_in  (digit_code),
      .seg_out (digit_seg)
   );

   // Outputs are computed from next-cycle state so the registered pins line up with the slot
   always_comb begin
      sel_d = '1;
      led_d = SEG_BLANK;
      dp_d  = 1'b1;
      if (state_d == SHOW) begin
         sel_d[idx_d] = 1'b0;
         led_d        = lz_blank[idx_d] ? SEG_BLANK : digit_seg;
         dp_d         = ~front_dp_d[idx_d];
      end
      frame_done_d = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= BLANK;
         cnt_q        <= '0;
         idx_q        <= '0;
         front_dig_q  <= '0;
         front_dp_q   <= '0;
         back_dig_q   <= '0;
         back_dp_q    <= '0;
         pending_q    <= 1'b0;
         in_ready_q   <= 1'b1;
         led_q        <= SEG_BLANK;
         dp_q         <= 1'b1;
         sel_q        <= '1;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         front_dig_q  <= front_dig_d;
         front_dp_q   <= front_dp_d;
         back_dig_q   <= back_dig_d;
         back_dp_q    <= back_dp_d;
         pending_q    <= pending_d;
         in_ready_q   <= in_ready_d;
         led_q        <= led_d;
         dp_q         <= dp_d;
         sel_q        <= sel_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign led_out    = led_q;
   assign dp_out     = dp_q;
   assign digit_sel  = sel_q;
   assign frame_done = frame_done_q;

endmodule
